// File: rtl/xor_ff_toggle.sv
// xor_ff_toggle: registered XOR toggle flip-flop with change flag and saturating toggle counter
module xor_ff_toggle #(
    parameter int                 WIDTH       = 1,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
    parameter int                 CNT_W       = 8
) (
    input  logic [WIDTH-1:0] in,
    input  logic             clk,
    output logic [WIDTH-1:0] out,
    input  logic             rst,
    output logic             toggled,
    output logic [CNT_W-1:0] toggle_count
);
    logic [WIDTH-1:0] out_q, out_d;
    logic             toggled_q, toggled_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        out_d     = out_q ^ in;
        toggled_d = |in;
        cnt_d     = (toggled_d && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= RESET_VALUE;
            toggled_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            out_q     <= out_d;
            toggled_q <= toggled_d;
            cnt_q     <= cnt_d;
        end
    end
    assign out          = out_q;
    assign toggled      = toggled_q;
    assign toggle_count = cnt_q;
endmodule

// File: tb/tb_xor_ff_toggle.sv
// tb_xor_ff_toggle: directed-vector bench for a 1-bit and a 4-bit/3-bit-counter toggle flop
`timescale 1ns/1ps
module tb_xor_ff_toggle;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in1 = 1'b0;
    logic [3:0] in4 = 4'b0;
    logic       out1, tog1, tog4;
    logic [3:0] out4;
    logic [7:0] cnt1;
    logic [2:0] cnt4;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    xor_ff_toggle #(.WIDTH(1), .CNT_W(8)) dut1 (
        .in(in1), .clk(clk), .out(out1), .rst(rst), .toggled(tog1), .toggle_count(cnt1)
    );
    xor_ff_toggle #(.WIDTH(4), .RESET_VALUE(4'b0000), .CNT_W(3)) dut4 (
        .in(in4), .clk(clk), .out(out4), .rst(rst), .toggled(tog4), .toggle_count(cnt4)
    );

    task automatic step(input logic r, input logic i1, input logic [3:0] i4);
        rst = r;
        in1 = i1;
        in4 = i4;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b1, 4'b1111);
            checks++;
            if (out1 !== 1'b0 || tog1 !== 1'b0 || cnt1 !== 8'd0) begin
                errors++;
                $display("FAIL reset1[%0d]: got out=%b tog=%b cnt=%0d, want 0 0 0", k, out1, tog1, cnt1);
            end
            checks++;
            if (out4 !== 4'b0000 || tog4 !== 1'b0 || cnt4 !== 3'd0) begin
                errors++;
                $display("FAIL reset4[%0d]: got out=%b tog=%b cnt=%0d, want 0000 0 0", k, out4, tog4, cnt4);
            end
        end
    endtask

    task automatic test_hold();
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 4'b0000);
            checks++;
            if (out1 !== 1'b0 || tog1 !== 1'b0 || cnt1 !== 8'd0) begin
                errors++;
                $display("FAIL hold[%0d]: got out=%b tog=%b cnt=%0d, want 0 0 0", k, out1, tog1, cnt1);
            end
        end
    endtask

    task automatic test_toggle_seq();
        logic [7:0] vin  = 8'b1111_1101;
        logic [7:0] vout = 8'b1010_1011;
        int         vcnt [8] = '{1, 1, 2, 3, 4, 5, 6, 7};
        for (int k = 0; k < 8; k++) begin
            step(1'b0, vin[k], 4'b0000);
            checks++;
            if (out1 !== vout[k] || tog1 !== vin[k] || cnt1 !== 8'(vcnt[k])) begin
                errors++;
                $display("FAIL toggle_seq[%0d]: got out=%b tog=%b cnt=%0d, want %b %b %0d",
                         k, out1, tog1, cnt1, vout[k], vin[k], vcnt[k]);
            end
        end
    endtask

    task automatic test_div2();
        time t_rise [2];
        int  n_rise = 0;
        logic prev;
        step(1'b1, 1'b0, 4'b0000);
        prev = out1;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b1, 4'b0000);
            checks++;
            if (out1 !== 1'(k % 2) || tog1 !== 1'b1 || cnt1 !== 8'(k)) begin
                errors++;
                $display("FAIL div2[%0d]: got out=%b tog=%b cnt=%0d, want %0d 1 %0d",
                         k, out1, tog1, cnt1, k % 2, k);
            end
            if (prev === 1'b0 && out1 === 1'b1 && n_rise < 2) begin
                t_rise[n_rise] = $time;
                n_rise++;
            end
            prev = out1;
        end
        checks++;
        if (n_rise != 2 || t_rise[1] - t_rise[0] != 20) begin
            errors++;
            $display("FAIL div2_period: got rises=%0d period=%0t, want 2 rises 20ns",
                     n_rise, n_rise == 2 ? t_rise[1] - t_rise[0] : 0);
        end
    endtask

    task automatic test_reset_priority();
        step(1'b0, 1'b1, 4'b0000);
        checks++;
        if (out1 !== 1'b1 || cnt1 !== 8'd11) begin
            errors++;
            $display("FAIL prio_pre: got out=%b cnt=%0d, want 1 11", out1, cnt1);
        end
        step(1'b1, 1'b1, 4'b1111);
        checks++;
        if (out1 !== 1'b0 || tog1 !== 1'b0 || cnt1 !== 8'd0) begin
            errors++;
            $display("FAIL prio_rst: got out=%b tog=%b cnt=%0d, want 0 0 0", out1, tog1, cnt1);
        end
        step(1'b0, 1'b1, 4'b0000);
        checks++;
        if (out1 !== 1'b1 || tog1 !== 1'b1 || cnt1 !== 8'd1) begin
            errors++;
            $display("FAIL prio_resume: got out=%b tog=%b cnt=%0d, want 1 1 1", out1, tog1, cnt1);
        end
    endtask

    task automatic test_multibit_sat();
        logic [3:0] vin  [11] = '{4'b1010, 4'b0001, 4'b0011, 4'b1111, 4'b1000, 4'b0110,
                                  4'b0101, 4'b1111, 4'b0010, 4'b0100, 4'b0000};
        logic [3:0] vout [11] = '{4'b1010, 4'b1011, 4'b1000, 4'b0111, 4'b1111, 4'b1001,
                                  4'b1100, 4'b0011, 4'b0001, 4'b0101, 4'b0101};
        int         vcnt [11] = '{1, 2, 3, 4, 5, 6, 7, 7, 7, 7, 7};
        for (int k = 0; k < 11; k++) begin
            step(1'b0, 1'b0, vin[k]);
            checks++;
            if (out4 !== vout[k] || tog4 !== (|vin[k]) || cnt4 !== 3'(vcnt[k])) begin
                errors++;
                $display("FAIL multibit[%0d]: got out=%b tog=%b cnt=%0d, want %b %b %0d",
                         k, out4, tog4, cnt4, vout[k], |vin[k], vcnt[k]);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_hold();
        test_toggle_seq();
        test_div2();
        test_reset_priority();
        test_multibit_sat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
